// File: rtl/d_mem_arb_if.sv
// Request/response bundle between the requesters and the shared memory arbiter.
//
// Handshake: a port raises re and/or we together with addr/wdata and holds
// them until its done bit pulses. rdy high means the arbiter is idle, so it
// accepts one requesting port on the next clock edge. On that edge it
// captures the port's fields, drops rdy and raises that port's gnt bit.
// done[p] is a one-cycle pulse that ends the transaction. rd_data is valid
// with the done pulse of a read. A request still held after done is taken
// as a new request.
interface d_mem_arb_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 64
);
  logic [NUM_PORTS-1:0]        re;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]           rd_data;
  logic [NUM_PORTS-1:0]        done;
  logic [NUM_PORTS-1:0]        gnt;
  logic                        rdy;

  modport master (
    output re, we, addr, wdata,
    input  rd_data, done, gnt, rdy
  );

  modport slave (
    input  re, we, addr, wdata,
    output rd_data, done, gnt, rdy
  );
endinterface

// File: rtl/d_mem_arb.sv
// Round-robin arbiter in front of a single shared line-wide memory.
// It serves one access at a time. Each access takes LATENCY clocks from
// acceptance to commit, followed by one DONE cycle.
module d_mem_arb #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 64,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  d_mem_arb_if.slave  bus,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(LATENCY - 1);
  localparam logic [PW-1:0] PORT_LAST = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [PW-1:0]          cur_port;
  logic                   cur_we;
  logic [ADDR_W-1:0]      cur_addr;
  logic [DATA_W-1:0]      cur_wdata;
  logic [PW-1:0]          last_gnt;
  logic [DATA_W-1:0]      rd_data_q;
  logic [NUM_PORTS-1:0]   done_q;
  logic [NUM_PORTS-1:0]   gnt_q;
  logic                   rdy_q;

  // The array stores data XOR address. A power-up cleared array therefore
  // reads back word i = i. The array itself is never reset.
  logic [DATA_W-1:0]      mem_x [DEPTH];

  logic [NUM_PORTS-1:0]   req;
  logic                   found;
  logic [PW-1:0]          sel;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   commit;

  assign commit = (state == BUSY) && (cnt == CNT_LAST);

  // Round-robin pick: scan from last_gnt+1 and take the first requesting port.
  always_comb begin
    req       = bus.re | bus.we;
    found     = 1'b0;
    sel       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!found && req[p] && (p == ((int'(last_gnt) + k) % NUM_PORTS))) begin
          found     = 1'b1;
          sel       = PW'(p);
          sel_we    = bus.we[p];
          sel_addr  = bus.addr[p*ADDR_W +: ADDR_W];
          sel_wdata = bus.wdata[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Control FSM. The captured request and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_port  <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      last_gnt  <= PORT_LAST;
      rd_data_q <= '0;
      done_q    <= '0;
      gnt_q     <= '0;
      rdy_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= BUSY;
            cnt       <= '0;
            cur_port  <= sel;
            cur_we    <= sel_we;
            cur_addr  <= sel_addr;
            cur_wdata <= sel_wdata;
            last_gnt  <= sel;
            gnt_q     <= NUM_PORTS'(1) << sel;
            rdy_q     <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state  <= DONE;
            done_q <= NUM_PORTS'(1) << cur_port;
            if (!cur_we) begin
              rd_data_q <= mem_x[cur_addr] ^ DATA_W'(cur_addr);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          cnt    <= '0;
          done_q <= '0;
          gnt_q  <= '0;
          rdy_q  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write commit. A reset during BUSY has already forced IDLE, so an
  // interrupted write never reaches the array.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur_we) begin
      mem_x[cur_addr] <= cur_wdata ^ DATA_W'(cur_addr);
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.done    = done_q;
  assign bus.gnt     = gnt_q;
  assign bus.rdy     = rdy_q;
  assign dbg_state   = state;

endmodule

// File: doc/d_mem_arb.md
# d_mem_arb

Parametrised, multi-port successor to the single-port 4-clock data memory. It arbitrates read/write requests from NUM_PORTS requesters (cores or caches) into one shared line-wide memory array with a configurable access latency. Request fields are captured at acceptance and completion is signalled per port. It sits between the per-core caches and the backing store in the multicore memory subsystem.

## Interface
- NUM_PORTS, 2: requester count, 1..8
- ADDR_W, 11: word address width; depth = 2^ADDR_W words
- DATA_W, 64: word (cache line) width
- LATENCY, 4: access clocks from acceptance to completion, >=1
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- re  in  NUM_PORTS  per-port read request, held until that port's done
- we  in  NUM_PORTS  per-port write request, held until that port's done
- addr  in  NUM_PORTS*ADDR_W  port p address at [p*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  port p write data at [p*DATA_W +: DATA_W]
- rd_data  out  DATA_W  last completed read data
- done  out  NUM_PORTS  one-cycle completion pulse to the owning port
- gnt  out  NUM_PORTS  one-hot owner during BUSY/DONE, 0 in IDLE
- rdy  out  1  high only in IDLE (memory can accept)

## Operation
- States: IDLE, BUSY, DONE. All outputs are registered or decoded from registered state.
- IDLE: a port requests when re[p]|we[p]. If any port requests, the block grants one by round-robin. Search starts at last_gnt+1, wraps modulo NUM_PORTS, and takes the first requester.
- On acceptance, capture port index, op, address and write data. Go to BUSY with cnt=0 and set last_gnt=p.
- re[p] and we[p] both high: the operation is a write.
- BUSY: cnt increments each clock.
  - When cnt==LATENCY-1, the next edge commits the operation: a write stores captured wdata at captured addr; a read loads mem[addr] into rd_data.
  - The same edge moves the block to DONE.
- DONE: lasts one cycle. done[p]=1, gnt[p]=1, rd_data valid. Always moves to IDLE. No acceptance occurs in DONE.
- The requester deasserts re/we by the edge ending DONE. A request still held in the following IDLE is treated as a new request.
- Live addr/wdata changes after acceptance have no effect.
- rd_data holds its value across writes and idle periods. It changes only on read commit.
- Memory array is not reset. Simulation initial contents: word i = i zero-extended to DATA_W.

## Timing
- Reset values:
  - state=IDLE, cnt=0, rd_data=0, done=0, gnt=0, rdy=1.
  - last_gnt=NUM_PORTS-1, so port 0 has first priority.
- Acceptance at edge A. Commit at edge A+LATENCY. done high from A+LATENCY to A+LATENCY+1.
- Back-to-back from one port: the next acceptance is no earlier than edge A+LATENCY+2. Throughput is one access per LATENCY+2 clocks.
- LATENCY=1: BUSY lasts one cycle; commit at A+1.
- Reset mid-BUSY:
  - Immediately IDLE; done and gnt drop asynchronously.
  - Pending write is aborted and memory is unchanged.
  - rd_data is cleared to 0.
- Reset during DONE: the done pulse is truncated; the already-committed write remains.
- Non-requesting ports are never granted. With a single requester, that port is granted regardless of last_gnt.
- Address wraps naturally within 2^ADDR_W. There is no out-of-range condition.

## Test plan
- Reset, then port0 re addr=0x005 held: rdy=0 after acceptance. done[0] pulses exactly 4 clocks after the acceptance edge with rd_data=0x0000_0000_0000_0005. gnt=2'b01 during BUSY/DONE. rdy=1 after.
- Port1 we addr=0x010 wdata=0xDEAD_BEEF_CAFE_F00D; change wdata to 0 one cycle after acceptance. Then port1 re addr=0x010: rd_data=0xDEADBEEFCAFEF00D. rd_data unchanged during the write.
- Ports 0 and 1 both hold re continuously (re addr 0x001 / 0x002) from reset: grants alternate 0,1,0,1. rd_data alternates 0x1 and 0x2. Each done arrives 6 clocks apart.
- Port0 asserts re and we together, addr=0x020, wdata=0x55: treated as a write; rd_data does not change. A subsequent read of 0x020 returns 0x55.
- Port0 we addr=0x030 wdata=0xAA; assert rst_n=0 when cnt=2. done never pulses, rdy=1 immediately. A read of 0x030 after reset returns 0x30.
- Instance with NUM_PORTS=4, LATENCY=1, all four ports reading: grant order 0,1,2,3,0. Each done comes 1 clock after its acceptance; accesses complete 3 clocks apart.
